// File: rtl/demux_1x4_buf.sv
// rtl/demux_1x4_buf.sv - buffered 1-to-4 demultiplexer with a 2-entry in-order FIFO
module demux_1x4_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_select,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic [DATA_WIDTH-1:0] out2_data,
    output logic [DATA_WIDTH-1:0] out3_data,
    output logic [DATA_WIDTH-1:0] out4_data,
    output logic [1:0]            count
);

    logic [1:0]            sel_mem  [2];
    logic [DATA_WIDTH-1:0] data_mem [2];
    logic                  wp;
    logic                  rp;
    logic [1:0]            count_q;
    logic                  push;
    logic                  pop;
    logic                  not_empty;
    logic [1:0]            head_sel;
    logic [DATA_WIDTH-1:0] head_data;

    assign count     = count_q;
    assign not_empty = (count_q != 2'd0);
    assign head_sel  = sel_mem[rp];
    assign head_data = data_mem[rp];

    // Ready looks only at registered occupancy, so a pop never opens a slot in the same cycle.
    assign in_ready  = (count_q != 2'd2);
    assign push      = in_valid & in_ready;
    assign pop       = |(out_valid & out_ready);

    always_comb begin
        out_valid = 4'b0000;
        out1_data = '0;
        out2_data = '0;
        out3_data = '0;
        out4_data = '0;
        if (not_empty) begin
            case (head_sel)
                2'b00: begin
                    out_valid = 4'b0001;
                    out1_data = head_data;
                end
                2'b01: begin
                    out_valid = 4'b0010;
                    out2_data = head_data;
                end
                2'b10: begin
                    out_valid = 4'b0100;
                    out3_data = head_data;
                end
                default: begin
                    out_valid = 4'b1000;
                    out4_data = head_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= 2'd0;
            wp      <= 1'b0;
            rp      <= 1'b0;
        end else begin
            if (push) begin
                wp <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem[wp]  <= in_select;
            data_mem[wp] <= in_data;
        end
    end

endmodule

// File: tb/tb_demux_1x4_buf.sv
// tb/tb_demux_1x4_buf.sv - scoreboard bench for demux_1x4_buf
module tb_demux_1x4_buf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_select;
    logic [DW-1:0] in_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [DW-1:0] out1_data;
    logic [DW-1:0] out2_data;
    logic [DW-1:0] out3_data;
    logic [DW-1:0] out4_data;
    logic [1:0]    count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW+1:0] sb[$];

    demux_1x4_buf #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_select (in_select),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .out4_data (out4_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0]    exp_valid;
        logic [DW-1:0] exp_data [4];
        int            hsel;
        exp_valid = 4'b0000;
        for (int k = 0; k < 4; k++) exp_data[k] = '0;
        if (sb.size() != 0) begin
            hsel           = int'(sb[0][DW+1:DW]);
            exp_valid[hsel] = 1'b1;
            exp_data[hsel]  = sb[0][DW-1:0];
        end
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(sb.size() != 2));
        chk({tag, ".count"}, 64'(count), 64'(sb.size()));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
        chk({tag, ".out1_data"}, 64'(out1_data), 64'(exp_data[0]));
        chk({tag, ".out2_data"}, 64'(out2_data), 64'(exp_data[1]));
        chk({tag, ".out3_data"}, 64'(out3_data), 64'(exp_data[2]));
        chk({tag, ".out4_data"}, 64'(out4_data), 64'(exp_data[3]));
    endtask

    // Drive one cycle of stimulus, check at the falling edge, then advance the model.
    task automatic cycle(input string tag, input logic v, input logic [1:0] sel,
                         input logic [DW-1:0] data, input logic [3:0] rdy);
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_select = sel;
        in_data   = data;
        out_ready = rdy;
        @(negedge clk);
        check_outputs(tag);
        do_push = v && (sb.size() != 2);
        do_pop  = (sb.size() != 0) && rdy[sb[0][DW+1:DW]];
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back({sel, data});
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        rstn = 1'b0;
        sb.delete();
        #1;
        check_outputs(tag);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_select = 2'b00;
        in_data   = '0;
        out_ready = 4'b0000;
        #2;
        check_outputs("por");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // single delivery with a held word
        cycle("single_push", 1'b1, 2'b10, 32'hDEAD_BEEF, 4'b0000);
        for (int i = 0; i < 3; i++) cycle("single_hold", 1'b0, 2'b00, 32'h0, 4'b0000);
        cycle("single_pop", 1'b0, 2'b00, 32'h0, 4'b0100);
        cycle("single_gone", 1'b0, 2'b00, 32'h0, 4'b0000);

        // streaming to all four channels
        for (int i = 0; i < 4; i++) cycle("stream", 1'b1, 2'(i), 32'(i + 1), 4'b1111);
        cycle("stream_tail", 1'b0, 2'b00, 32'h0, 4'b1111);
        cycle("stream_empty", 1'b0, 2'b00, 32'h0, 4'b1111);

        // full and head-of-line blocking
        cycle("hol_a", 1'b1, 2'b01, 32'hAAAA_0001, 4'b0100);
        cycle("hol_b", 1'b1, 2'b10, 32'hBBBB_0002, 4'b0100);
        cycle("hol_c", 1'b1, 2'b11, 32'hCCCC_0003, 4'b0100);
        cycle("hol_rel_a", 1'b1, 2'b11, 32'hCCCC_0004, 4'b0010);
        cycle("hol_b_out", 1'b0, 2'b00, 32'h0, 4'b0100);
        cycle("hol_empty", 1'b0, 2'b00, 32'h0, 4'b0000);

        // simultaneous push and pop at count 1
        cycle("pp_fill", 1'b1, 2'b00, 32'h1111_0000, 4'b0000);
        cycle("pp_both", 1'b1, 2'b11, 32'h0000_0055, 4'b0001);
        cycle("pp_new_head", 1'b0, 2'b00, 32'h0, 4'b0000);
        cycle("pp_drain", 1'b0, 2'b00, 32'h0, 4'b1000);

        // ready on non-selected channels is ignored
        cycle("ign_push", 1'b1, 2'b10, 32'h7777_7777, 4'b0000);
        cycle("ign_1", 1'b0, 2'b00, 32'h0, 4'b1011);
        cycle("ign_2", 1'b0, 2'b00, 32'h0, 4'b1011);
        cycle("ign_drain", 1'b0, 2'b00, 32'h0, 4'b0100);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 2'($urandom), 32'($urandom), 4'($urandom));
        end

        // reset with two words buffered, then confirm nothing stale appears
        cycle("rst_fill1", 1'b1, 2'b01, 32'h1234_5678, 4'b0000);
        cycle("rst_fill2", 1'b1, 2'b11, 32'h8765_4321, 4'b0000);
        cycle("rst_full", 1'b0, 2'b00, 32'h0, 4'b0000);
        apply_reset("mid_rst");
        for (int i = 0; i < 2; i++) cycle("post_rst", 1'b0, 2'b00, 32'h0, 4'b1111);
        cycle("post_rst_push", 1'b1, 2'b00, 32'h0000_00A5, 4'b0000);
        cycle("post_rst_word", 1'b0, 2'b00, 32'h0, 4'b0001);
        cycle("post_rst_end", 1'b0, 2'b00, 32'h0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_1x4_buf.md
# demux_1x4_buf

Buffered 1-to-4 demultiplexer: accepts a data word with a 2-bit destination select over a valid/ready handshake, holds it in a 2-entry FIFO, and presents it on exactly one of four output channels, each with its own valid/ready handshake. It is the distribution counterpart of the 4:1 selection mux. One source fans out to up to four consumers, for example write-back or forwarding targets in the pipeline. Ordering is strictly preserved: the head entry blocks later entries until its selected consumer accepts it.

## Interface
Parameters:
- DATA_WIDTH, 32, width of every data port and of each FIFO data field.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  source presents a word this cycle.
- in_ready  output  1  block can accept a word this cycle.
- in_select  input  2  destination channel: 2'b00→ch1, 2'b01→ch2, 2'b10→ch3, 2'b11→ch4.
- in_data  input  DATA_WIDTH  word to deliver.
- out_valid  output  4  bit k-1 set means channel k holds a word; at most one bit set.
- out_ready  input  4  bit k-1 set means channel k consumer accepts this cycle.
- out1_data … out4_data  output  DATA_WIDTH each  per-channel data.
- count  output  2  FIFO occupancy, 0..2.

## Operation
- State: two entries, each {select[1:0], data}; 1-bit write pointer wp, 1-bit read pointer rp, 2-bit count.
- in_ready = (count != 2). It depends only on registered state; there is no combinational path from out_ready to in_ready.
- Push = in_valid & in_ready: write {in_select, in_data} at wp, then wp toggles.
- Head = entry at rp, valid when count != 0.
- out_valid[k] = (count != 0) & (head.select == k).
- The selected channel's outN_data = head.data. Every non-selected channel, and every channel when empty, drives 0.
- Pop = |(out_valid & out_ready): rp toggles. out_ready bits on non-selected channels are ignored.
- count update: push only → +1; pop only → −1; push and pop together → unchanged.
- Pointer wrap: 1-bit pointers wrap naturally 1→0.
- Boundary conditions:
  - Full (count=2): in_valid is ignored and no write occurs. A pop in the same cycle frees a slot, but in_ready stays 0 that cycle.
  - Empty (count=0): out_valid=4'b0000 and all outN_data = 0.
  - Count=1 with push and pop in the same cycle: the head advances to the new entry and count stays 1.
  - in_select and in_data are sampled only on push. Changes while in_ready=0 have no effect.
- Reset (rstn low, at any time including mid-transfer):
  - Immediately: count=0, wp=0, rp=0, out_valid=0, all outN_data=0, in_ready=1.
  - Buffered entries are discarded. FIFO data storage need not be cleared.

## Timing
- Latency: a word pushed in cycle N is visible on its channel from cycle N+1.
- Throughput: one word per cycle sustained when the head's consumer holds out_ready=1.
- A word stays on its channel, stable, until the cycle its out_ready bit is sampled high. It disappears in the cycle after that.
- Backpressure: if the head consumer stalls, two words are accepted and then in_ready drops to 0 on the cycle after the second push.
- After rstn deasserts, the first push may occur on the first rising edge.

## Test plan
- Reset: assert rstn=0 mid-stream with count=2 → immediately count=0, out_valid=4'b0000, in_ready=1, all outN_data=0; no stale word appears after release.
- Single delivery: push {sel=2'b10, data=32'hDEAD_BEEF} with out_ready=4'b0000 → next cycle out_valid=4'b0100, out3_data=32'hDEAD_BEEF, other data 0. Hold 3 cycles, then out_ready[2]=1 → popped, out_valid=0 the next cycle.
- Streaming: push sel 0,1,2,3 with data 1,2,3,4 in consecutive cycles, out_ready=4'b1111 → out_valid shows 0001,0010,0100,1000 in cycles N+1..N+4 with matching data; count never exceeds 1; in_ready stays 1.
- Full / head-of-line blocking: push sel=1 (A), then sel=2 (B), with out_ready=4'b0100 → A stalls; count=2, in_ready=0; a third in_valid is not accepted. Raising out_ready[1] → A is delivered, then B on out3 the next cycle.
- Simultaneous push/pop at count=1: head sel=0 with out_ready[0]=1 while pushing sel=3 data 32'h55 → count stays 1; next cycle out_valid=4'b1000, out4_data=32'h55.
- Ignored ready: head sel=2 with out_ready=4'b1011 → no pop; word held and count unchanged.
